mem_io: RTL and testbench
=========================

# mem_io

Data-memory and memory-mapped I/O stage that sits directly downstream of the CPU. It takes the CPU's ALU address, store data and write strobe, and returns load data on the CPU's `Din` within the same cycle. It holds a 240-byte data RAM and a small peripheral page for the minesweeper game:
- a debounced-edge button event FIFO
- an LFSR random source
- a tick counter
- an LED register

## Interface
- `FIFO_DEPTH`, 4: button event FIFO entries; power of two, 2..16.
- `TICK_DIV`, 50000: CLK cycles per TICK increment; ≥ 1.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RESET_L`  in  1  reset, asynchronous, active-low.
- `ADDR`  in  8  byte address (CPU `DataD`).
- `WDATA`  in  8  store data (CPU `DataB`).
- `MW`  in  1  memory write strobe, one cycle per store.
- `RD`  in  1  load strobe from CPU decode (opcode 0010); qualifies read side effects only.
- `RDATA`  out  8  load data (CPU `Din`), combinational from `ADDR` and current state.
- `BTN`  in  5  raw asynchronous button levels, active-high.
- `LED`  out  8  LED register.

## Operation
- Address map:
  - 0x00–0xEF RAM.
  - 0xF0 BTN_STATUS.
  - 0xF1 BTN_DATA.
  - 0xF2 RAND.
  - 0xF3 TICK.
  - 0xF4 LED.
  - 0xF5–0xFF reserved: read 0x00, writes ignored.
- RAM:
  - Asynchronous read, synchronous write on `MW`.
  - Not cleared by reset; contents are undefined until written.
- BTN_STATUS read: {overflow, 0, 0, count[4:0]}.
  - `count` is the number of FIFO entries, 0..FIFO_DEPTH.
  - bit 7 is the sticky overflow flag.
  - Any write clears overflow.
- BTN_DATA read returns the FIFO head {3'b0, mask[4:0]}, or 0x00 when empty.
  - `RD` with a non-empty FIFO pops at the clock edge.
  - `RD` with an empty FIFO does nothing.
  - Writes are ignored.
- Button path, per bit:
  - 2-flop synchronizer, then a previous-value flop.
  - `edge = sync & ~prev`.
  - A cycle with a nonzero edge mask pushes one entry holding the mask, so multiple buttons rising together produce one entry.
- FIFO boundary rules:
  - Push when full and no pop: entry dropped, overflow set.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: no pop (read returns 0x00), push happens.
  - Pointers wrap modulo FIFO_DEPTH.
- RAND:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  - Advances every cycle.
  - A write loads WDATA, or 0x01 if WDATA is 0x00. The write replaces the advance for that cycle.
- TICK:
  - A prescaler counts 0..TICK_DIV-1.
  - TICK increments when the prescaler wraps; 8-bit, wraps 0xFF→0x00.
  - A write loads WDATA into TICK and clears the prescaler.
- LED: a write loads WDATA; a read returns the LED register.
- `MW` and `RD` together: the write applies, and any pop applies independently.
- `RD` has no effect at addresses other than 0xF1.

## Timing
- Reset values, asserted immediately and asynchronously:
  - LED 0x00.
  - FIFO empty, pointers 0, overflow 0.
  - LFSR 0x01.
  - TICK 0x00, prescaler 0.
  - Sync and prev flops 0: a button held through reset yields one event after release of reset.
- Reset asserted mid-operation discards FIFO contents and any pending edge.
- Read latency is 0 cycles: `RDATA` is valid in the same cycle as `ADDR`.
- A write at edge k is visible to reads from cycle k onward.
- A button rising before edge k is synchronized at edge k+1, pushed at edge k+2, and visible in BTN_STATUS after edge k+2.
- Each pop removes exactly one entry per `RD` cycle.

## Structure
- Package `mem_io_pkg` holds:
  - address constants ADDR_BTN_STATUS, ADDR_BTN_DATA, ADDR_RAND, ADDR_TICK, ADDR_LED, RAM_TOP = 0xEF.
  - LFSR_SEED = 0x01.
- Sub-module `event_fifo`: parameterized synchronous FIFO with push/pop/full/empty/count and async active-low reset.
- RAM, LFSR, tick counter, LED register and the read mux live in `mem_io`.

## Test plan
- Store 0x5A at 0x10, load 0x10 → `RDATA` = 0x5A. Store at 0xEF/0xF8, load → 0xEF holds data, 0xF8 reads 0x00.
- Pulse BTN[2] → after 3 edges STATUS = 0x01. Load 0xF1 with `RD` → 0x04, then STATUS = 0x00. Further reads of 0xF1 → 0x00.
- Generate 6 separate presses with no pops (depth 4) → STATUS = 0x84. Pops return the first 4 masks in order. Write 0xF0 → overflow cleared.
- FIFO full with push and pop in the same cycle → count stays 4, overflow stays 0. Empty FIFO with push and `RD` in the same cycle → `RDATA` 0x00, count 1.
- After reset, RAND reads 0x01, then 0x02 next cycle. Write 0x00 to 0xF2 → reads 0x01. TICK_DIV = 3 → TICK increments every 3 cycles and wraps at 0xFF.
- Assert `RESET_L` low mid-run with FIFO holding 2 entries and LED = 0xAA → LED 0x00, STATUS 0x00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants, types and LFSR helpers for the mem_io data-memory / MMIO stage.
package mem_io_pkg;

  localparam logic [7:0] RAM_TOP         = 8'hEF;
  localparam logic [7:0] ADDR_BTN_STATUS = 8'hF0;
  localparam logic [7:0] ADDR_BTN_DATA   = 8'hF1;
  localparam logic [7:0] ADDR_RAND       = 8'hF2;
  localparam logic [7:0] ADDR_TICK       = 8'hF3;
  localparam logic [7:0] ADDR_LED        = 8'hF4;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Taps x^8+x^6+x^5+x^4 map to state bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic       overflow;
    logic [1:0] zero;
    logic [4:0] count;
  } btn_status_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // The all-zero state would lock the LFSR, so a zero load becomes the seed.
  function automatic logic [7:0] lfsr_load(input logic [7:0] v);
    return (v == 8'h00) ? LFSR_SEED : v;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO with occupancy count; a pop on an empty FIFO is ignored,
// and a push when full only lands if a pop frees a slot in the same cycle.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_io.sv
// Data RAM plus minesweeper peripheral page (button FIFO, LFSR, tick, LED)
// with a zero-latency combinational read path back to the CPU.
module mem_io
  import mem_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 50000
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic       MW,
  input  logic       RD,
  output logic [7:0] RDATA,
  input  logic [4:0] BTN,
  output logic [7:0] LED
);

  localparam int RAM_BYTES = int'(RAM_TOP) + 1;
  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    ram_q [RAM_BYTES];
  logic [4:0]    btn_sync1_q, btn_sync1_d;
  logic [4:0]    btn_sync2_q, btn_sync2_d;
  logic [4:0]    btn_prev_q,  btn_prev_d;
  logic [4:0]    edge_mask;
  logic          ovf_q, ovf_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    tick_q, tick_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    led_q, led_d;

  logic             wr_ram, wr_status, wr_rand, wr_tick, wr_led;
  logic             push_evt, pop_req;
  logic [4:0]       fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  btn_status_t      status;

  always_comb begin
    wr_ram    = MW && (ADDR <= RAM_TOP);
    wr_status = MW && (ADDR == ADDR_BTN_STATUS);
    wr_rand   = MW && (ADDR == ADDR_RAND);
    wr_tick   = MW && (ADDR == ADDR_TICK);
    wr_led    = MW && (ADDR == ADDR_LED);
    pop_req   = RD && (ADDR == ADDR_BTN_DATA);
  end

  // Button path: two-flop synchronizer, then a previous-value flop for rising edges.
  always_comb begin
    btn_sync1_d = BTN;
    btn_sync2_d = btn_sync1_q;
    btn_prev_d  = btn_sync2_q;
    edge_mask   = btn_sync2_q & ~btn_prev_q;
    push_evt    = |edge_mask;
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      btn_prev_q  <= '0;
    end else begin
      btn_sync1_q <= btn_sync1_d;
      btn_sync2_q <= btn_sync2_d;
      btn_prev_q  <= btn_prev_d;
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (5)
  ) u_event_fifo (
    .clk   (CLK),
    .rst_n (RESET_L),
    .push  (push_evt),
    .pop   (pop_req),
    .din   (edge_mask),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // An overflow raised in the same cycle as a status write still sticks.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_status) ovf_d = 1'b0;
    if (push_evt && fifo_full && !pop_req) ovf_d = 1'b1;
  end

  always_comb begin
    lfsr_d = wr_rand ? lfsr_load(WDATA) : lfsr_next(lfsr_q);
  end

  always_comb begin
    tick_d = tick_q;
    pre_d  = pre_q;
    if (wr_tick) begin
      tick_d = WDATA;
      pre_d  = '0;
    end else if (pre_q == PRE_MAX) begin
      tick_d = tick_q + 8'd1;
      pre_d  = '0;
    end else begin
      pre_d  = pre_q + PW'(1);
    end
  end

  always_comb begin
    led_d = wr_led ? WDATA : led_q;
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      ovf_q  <= 1'b0;
      lfsr_q <= LFSR_SEED;
      tick_q <= 8'h00;
      pre_q  <= '0;
      led_q  <= 8'h00;
    end else begin
      ovf_q  <= ovf_d;
      lfsr_q <= lfsr_d;
      tick_q <= tick_d;
      pre_q  <= pre_d;
      led_q  <= led_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ram) ram_q[ADDR] <= WDATA;
  end

  always_comb begin
    status.overflow = ovf_q;
    status.zero     = 2'b00;
    status.count    = 5'(fifo_count);
  end

  always_comb begin
    RDATA = 8'h00;
    if (ADDR <= RAM_TOP) begin
      RDATA = ram_q[ADDR];
    end else begin
      case (ADDR)
        ADDR_BTN_STATUS: RDATA = status;
        ADDR_BTN_DATA:   RDATA = fifo_empty ? 8'h00 : {3'b000, fifo_head};
        ADDR_RAND:       RDATA = lfsr_q;
        ADDR_TICK:       RDATA = tick_q;
        ADDR_LED:        RDATA = led_q;
        default:         RDATA = 8'h00;
      endcase
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_mem_io.sv
// Self-checking bench for mem_io: directed vector table, hand-built FIFO/reset
// sequences, then randomized traffic against a behavioural model.
module tb_mem_io;

  localparam int DEPTH = 4;
  localparam int TDIV  = 3;

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b0;
  logic [7:0] ADDR = 8'h00;
  logic [7:0] WDATA = 8'h00;
  logic       MW = 1'b0;
  logic       RD = 1'b0;
  logic [4:0] BTN = 5'h00;
  logic [7:0] RDATA;
  logic [7:0] LED;

  always #5 CLK = ~CLK;

  mem_io #(.FIFO_DEPTH(DEPTH), .TICK_DIV(TDIV)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .ADDR    (ADDR),
    .WDATA   (WDATA),
    .MW      (MW),
    .RD      (RD),
    .RDATA   (RDATA),
    .BTN     (BTN),
    .LED     (LED)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory arrays, a queue for the event FIFO, and the
  // button levels seen at the last three clock edges.
  logic [7:0] m_ram [256];
  bit         m_vld [256];
  logic [4:0] m_q [$];
  bit         m_ovf;
  logic [4:0] h1, h2, h3;
  logic [7:0] m_lfsr, m_tbase, m_led;
  int         m_cyc;

  function automatic void m_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    h1      = '0;
    h2      = '0;
    h3      = '0;
    m_lfsr  = 8'h01;
    m_tbase = 8'h00;
    m_cyc   = 0;
    m_led   = 8'h00;
  endfunction

  function automatic void m_step();
    logic [4:0] mask;
    bit         pop, lfsr_wr, tick_wr;
    logic       fb;
    if (!RESET_L) begin
      m_reset();
      return;
    end
    mask    = h2 & ~h3;
    pop     = RD && (ADDR == 8'hF1) && (m_q.size() > 0);
    lfsr_wr = 1'b0;
    tick_wr = 1'b0;
    if (MW) begin
      if (ADDR <= 8'hEF) begin
        m_ram[ADDR] = WDATA;
        m_vld[ADDR] = 1'b1;
      end else if (ADDR == 8'hF0) m_ovf = 1'b0;
      else if (ADDR == 8'hF2) begin
        m_lfsr  = (WDATA == 0) ? 8'h01 : WDATA;
        lfsr_wr = 1'b1;
      end else if (ADDR == 8'hF3) begin
        m_tbase = WDATA;
        m_cyc   = 0;
        tick_wr = 1'b1;
      end else if (ADDR == 8'hF4) m_led = WDATA;
    end
    if (!lfsr_wr) begin
      fb     = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
      m_lfsr = {m_lfsr[6:0], fb};
    end
    if (!tick_wr) m_cyc++;
    if (pop) void'(m_q.pop_front());
    if (mask != 0) begin
      if (m_q.size() < DEPTH) m_q.push_back(mask);
      else m_ovf = 1'b1;
    end
    h3 = h2;
    h2 = h1;
    h1 = BTN;
  endfunction

  function automatic bit m_rdata(input logic [7:0] a, output logic [7:0] v);
    v = 8'h00;
    if (a <= 8'hEF) begin
      v = m_ram[a];
      return m_vld[a];
    end
    case (a)
      8'hF0: v = {m_ovf, 2'b00, 5'(m_q.size())};
      8'hF1: v = (m_q.size() > 0) ? {3'b000, m_q[0]} : 8'h00;
      8'hF2: v = m_lfsr;
      8'hF3: v = 8'(int'(m_tbase) + m_cyc / TDIV);
      8'hF4: v = m_led;
      default: v = 8'h00;
    endcase
    return 1'b1;
  endfunction

  // One clock edge: model advances on the inputs held across the edge.
  task automatic cyc();
    m_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [4:0] mask);
    BTN = mask;
    cyc();
    BTN = 5'h00;
    cyc();
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    ADDR  = a;
    WDATA = d;
    MW    = 1'b1;
    cyc();
    MW    = 1'b0;
  endtask

  task automatic peek(input string name, input logic [7:0] a, input logic [7:0] exp);
    ADDR = a;
    #1;
    check(name, RDATA, exp);
  endtask

  typedef struct {
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[10];
  logic [4:0] ovf_masks[6];

  initial begin
    logic [7:0] ev;
    bit         ok;

    for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
    m_reset();

    tbl[0] = '{8'h10, 8'h5A, 8'h10, 8'h5A, "ram_10"};
    tbl[1] = '{8'hEF, 8'h33, 8'hEF, 8'h33, "ram_top"};
    tbl[2] = '{8'hF8, 8'h77, 8'hF8, 8'h00, "reserved_f8"};
    tbl[3] = '{8'hF5, 8'h12, 8'hF5, 8'h00, "reserved_f5"};
    tbl[4] = '{8'hF4, 8'hAA, 8'hF4, 8'hAA, "led_wr"};
    tbl[5] = '{8'hF2, 8'h00, 8'hF2, 8'h01, "rand_zero_load"};
    tbl[6] = '{8'hF2, 8'h80, 8'hF2, 8'h80, "rand_load"};
    tbl[7] = '{8'hF3, 8'hFE, 8'hF3, 8'hFE, "tick_load"};
    tbl[8] = '{8'hF1, 8'h55, 8'hF1, 8'h00, "btn_data_ro"};
    tbl[9] = '{8'h00, 8'hC3, 8'h10, 8'h5A, "ram_10_kept"};

    ovf_masks = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h03};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    RESET_L = 1'b1;
    m_reset();
    peek("rst_led", 8'hF4, 8'h00);
    check("rst_led_port", LED, 8'h00);
    peek("rst_status", 8'hF0, 8'h00);
    peek("rst_tick", 8'hF3, 8'h00);
    peek("rst_rand", 8'hF2, 8'h01);
    cyc();
    peek("rand_adv", 8'hF2, 8'h02);

    for (int i = 0; i < 10; i++) begin
      write(tbl[i].wa, tbl[i].wd);
      peek(tbl[i].name, tbl[i].ra, tbl[i].exp);
    end
    check("led_port", LED, 8'hAA);

    // Tick prescaler and wrap
    write(8'hF3, 8'hFD);
    peek("tick_n0", 8'hF3, 8'hFD);
    for (int n = 1; n <= 9; n++) begin
      cyc();
      check("tick_seq", RDATA, 8'(8'hFD + n / TDIV));
    end

    // Single press on BTN[2]
    ADDR = 8'hF0;
    BTN  = 5'b00100;
    cyc();
    BTN  = 5'h00;
    peek("btn_k", 8'hF0, 8'h00);
    cyc();
    peek("btn_k1", 8'hF0, 8'h00);
    cyc();
    peek("btn_k2", 8'hF0, 8'h01);
    RD = 1'b1;
    peek("btn_pop", 8'hF1, 8'h04);
    cyc();
    RD = 1'b0;
    peek("btn_after_pop", 8'hF0, 8'h00);
    RD = 1'b1;
    peek("btn_empty_rd", 8'hF1, 8'h00);
    cyc();
    RD = 1'b0;
    peek("btn_empty_rd2", 8'hF0, 8'h00);

    // Overflow: six presses into a four-deep FIFO
    for (int i = 0; i < 6; i++) press(ovf_masks[i]);
    cyc();
    cyc();
    peek("ovf_status", 8'hF0, 8'h84);
    RD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      peek("ovf_pop", 8'hF1, {3'b000, ovf_masks[i]});
      cyc();
    end
    RD = 1'b0;
    peek("ovf_drained", 8'hF0, 8'h80);
    write(8'hF0, 8'h00);
    peek("ovf_cleared", 8'hF0, 8'h00);

    // Full FIFO: push and pop land on the same edge
    for (int i = 0; i < 4; i++) press(ovf_masks[i]);
    cyc();
    peek("full_status", 8'hF0, 8'h04);
    BTN = 5'h10;
    cyc();
    BTN = 5'h00;
    cyc();
    RD = 1'b1;
    peek("full_head", 8'hF1, 8'h01);
    cyc();
    RD = 1'b0;
    peek("full_pushpop", 8'hF0, 8'h04);
    RD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      peek("full_order", 8'hF1, (i == 3) ? 8'h10 : {3'b000, ovf_masks[i + 1]});
      cyc();
    end
    RD = 1'b0;
    peek("full_empty", 8'hF0, 8'h00);

    // Empty FIFO: push and RD on the same edge
    BTN = 5'h08;
    cyc();
    BTN = 5'h00;
    cyc();
    RD = 1'b1;
    peek("empty_pushpop_rd", 8'hF1, 8'h00);
    cyc();
    RD = 1'b0;
    peek("empty_pushpop_cnt", 8'hF0, 8'h01);
    RD = 1'b1;
    peek("empty_pushpop_val", 8'hF1, 8'h08);
    cyc();
    RD = 1'b0;

    // Asynchronous reset mid-run with a held button
    write(8'hF4, 8'hAA);
    press(5'h01);
    press(5'h02);
    cyc();
    peek("pre_rst_status", 8'hF0, 8'h02);
    check("pre_rst_led", LED, 8'hAA);
    BTN = 5'h01;
    @(negedge CLK);
    #2;
    RESET_L = 1'b0;
    m_reset();
    #1;
    check("async_rst_status", RDATA, 8'h00);
    check("async_rst_led", LED, 8'h00);
    cyc();
    cyc();
    RESET_L = 1'b1;
    cyc();
    cyc();
    peek("held_btn_k1", 8'hF0, 8'h00);
    cyc();
    peek("held_btn_k2", 8'hF0, 8'h01);
    repeat (3) cyc();
    peek("held_btn_once", 8'hF0, 8'h01);
    BTN = 5'h00;

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    ADDR = 8'($urandom_range(0, 15));
        2:       ADDR = 8'($urandom_range(8'hE8, 8'hEF));
        3:       ADDR = 8'hF0;
        4, 5:    ADDR = 8'hF1;
        6:       ADDR = 8'hF2;
        7:       ADDR = 8'hF3;
        8:       ADDR = 8'hF4;
        default: ADDR = 8'($urandom_range(8'hF5, 8'hFF));
      endcase
      WDATA = 8'($urandom);
      MW    = ($urandom_range(0, 3) == 0);
      RD    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) BTN = 5'($urandom);
      #1;
      ok = m_rdata(ADDR, ev);
      if (ok) check("rand_rdata", RDATA, ev);
      check("rand_led", LED, m_led);
      cyc();
    end
    MW = 1'b0;
    RD = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
